// File: rtl/sprite_pkg.sv
// Shared sprite definitions: facing directions and screen geometry used by the
// blitter and the tank/bullet controllers.
package sprite_pkg;

    localparam int COORD_W  = 10;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

endpackage

// File: rtl/sprite_blitter_if.sv
// Pixel/ROM/compositor bundle between the sprite blitter and the video system.
// The master side is the video system (raster, game logic, sprite ROM).
interface sprite_blitter_if #(
    parameter int ADDR_W = 9,
    parameter int IDX_W  = 4
);
    import sprite_pkg::*;

    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic               blank;
    logic               frame_start;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic [1:0]         dir;
    logic               anim_en;
    logic               enable;
    logic [ADDR_W-1:0]  rom_addr;
    logic [IDX_W-1:0]   rom_q;
    logic [IDX_W-1:0]   pix_idx;
    logic               pix_hit;

    modport master (
        output DrawX, DrawY, blank, frame_start, pos_x, pos_y, dir, anim_en,
               enable, rom_q,
        input  rom_addr, pix_idx, pix_hit
    );

    modport slave (
        input  DrawX, DrawY, blank, frame_start, pos_x, pos_y, dir, anim_en,
               enable, rom_q,
        output rom_addr, pix_idx, pix_hit
    );

endinterface

// File: rtl/sprite_addr_xform.sv
// Combinational hit test, facing rotation and ROM address formation for one
// square sprite placed at (pos_x_i, pos_y_i).
module sprite_addr_xform
    import sprite_pkg::*;
#(
    parameter int SIZE   = 16,
    parameter int ADDR_W = 9
) (
    input  logic [COORD_W-1:0] draw_x_i,
    input  logic [COORD_W-1:0] draw_y_i,
    input  logic [COORD_W-1:0] pos_x_i,
    input  logic [COORD_W-1:0] pos_y_i,
    input  dir_t               dir_i,
    input  logic [ADDR_W-1:0]  frame_base_i,
    output logic               in_box_o,
    output logic [ADDR_W-1:0]  addr_o
);

    localparam int S_W = $clog2(SIZE);
    localparam logic [S_W-1:0] M = S_W'(SIZE - 1);

    logic [COORD_W:0] lx;
    logic [COORD_W:0] ly;
    logic [S_W-1:0]   lxs;
    logic [S_W-1:0]   lys;
    logic [S_W-1:0]   sx;
    logic [S_W-1:0]   sy;

    always_comb begin
        // 11-bit differences: a sprite hanging off the right/bottom edge is
        // clipped because DrawX never wraps back below pos.
        lx  = {1'b0, draw_x_i} - {1'b0, pos_x_i};
        ly  = {1'b0, draw_y_i} - {1'b0, pos_y_i};
        in_box_o = (draw_x_i >= pos_x_i) && (lx < (COORD_W + 1)'(SIZE)) &&
                   (draw_y_i >= pos_y_i) && (ly < (COORD_W + 1)'(SIZE));
        lxs = lx[S_W-1:0];
        lys = ly[S_W-1:0];
        sx  = lxs;
        sy  = lys;
        case (dir_i)
            DIR_UP: begin
                sx = lxs;
                sy = lys;
            end
            DIR_RIGHT: begin
                sx = lys;
                sy = M - lxs;
            end
            DIR_DOWN: begin
                sx = M - lxs;
                sy = M - lys;
            end
            default: begin
                sx = M - lys;
                sy = lxs;
            end
        endcase
        addr_o = frame_base_i | ADDR_W'({sy, sx});
    end

endmodule

// File: rtl/sprite_blitter.sv
// Positioned, rotatable, animated sprite renderer with 3-cycle latency from
// pixel coordinate to palette index / opaque-hit flag.
module sprite_blitter
    import sprite_pkg::*;
#(
    parameter int SIZE       = 16,
    parameter int FRAMES     = 2,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = 0,
    parameter int ANIM_DIV   = 8
) (
    input logic           vga_clk,
    input logic           reset,
    sprite_blitter_if.slave bus
);

    localparam int ADDR_W      = $clog2(SIZE * SIZE * FRAMES);
    localparam int S_W         = $clog2(SIZE);
    localparam int FR_W        = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int CNT_W       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int QUAL_STAGES = 2;

    logic [COORD_W-1:0]     pos_x_q, pos_x_d;
    logic [COORD_W-1:0]     pos_y_q, pos_y_d;
    dir_t                   dir_q, dir_d;
    logic                   enable_q, enable_d;
    logic [CNT_W-1:0]       anim_cnt_q, anim_cnt_d;
    logic [FR_W-1:0]        frame_q, frame_d;
    logic [ADDR_W-1:0]      rom_addr_q, rom_addr_d;
    logic [QUAL_STAGES-1:0] qual_q, qual_d;
    logic                   pix_hit_q, pix_hit_d;
    logic [IDX_W-1:0]       pix_idx_q, pix_idx_d;

    logic                   in_box;
    logic [ADDR_W-1:0]      xf_addr;
    logic [ADDR_W-1:0]      frame_base;

    assign frame_base = ADDR_W'(frame_q) << (2 * S_W);

    sprite_addr_xform #(
        .SIZE   (SIZE),
        .ADDR_W (ADDR_W)
    ) u_xform (
        .draw_x_i     (bus.DrawX),
        .draw_y_i     (bus.DrawY),
        .pos_x_i      (pos_x_q),
        .pos_y_i      (pos_y_q),
        .dir_i        (dir_q),
        .frame_base_i (frame_base),
        .in_box_o     (in_box),
        .addr_o       (xf_addr)
    );

    // Qualifiers ride alongside the ROM access so they meet rom_q in stage 3.
    genvar gi;
    generate
        for (gi = 0; gi < QUAL_STAGES; gi++) begin : g_qual
            if (gi == 0) begin : g_head
                assign qual_d[gi] = in_box && bus.blank && enable_q;
            end else begin : g_tail
                assign qual_d[gi] = qual_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        dir_d      = dir_q;
        enable_d   = enable_q;
        anim_cnt_d = anim_cnt_q;
        frame_d    = frame_q;
        if (bus.frame_start) begin
            pos_x_d  = bus.pos_x;
            pos_y_d  = bus.pos_y;
            dir_d    = dir_t'(bus.dir);
            enable_d = bus.enable;
            if (bus.anim_en) begin
                if (anim_cnt_q == CNT_W'(ANIM_DIV - 1)) begin
                    anim_cnt_d = '0;
                    frame_d    = (frame_q == FR_W'(FRAMES - 1)) ? '0 : frame_q + FR_W'(1);
                end else begin
                    anim_cnt_d = anim_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        rom_addr_d = in_box ? xf_addr : rom_addr_q;
        pix_hit_d  = qual_q[QUAL_STAGES-1] && (bus.rom_q != IDX_W'(TRANSP_IDX));
        pix_idx_d  = pix_hit_d ? bus.rom_q : '0;
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            dir_q      <= DIR_UP;
            enable_q   <= 1'b0;
            anim_cnt_q <= '0;
            frame_q    <= '0;
            rom_addr_q <= '0;
            qual_q     <= '0;
            pix_hit_q  <= 1'b0;
            pix_idx_q  <= '0;
        end else begin
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            dir_q      <= dir_d;
            enable_q   <= enable_d;
            anim_cnt_q <= anim_cnt_d;
            frame_q    <= frame_d;
            rom_addr_q <= rom_addr_d;
            qual_q     <= qual_d;
            pix_hit_q  <= pix_hit_d;
            pix_idx_q  <= pix_idx_d;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.pix_hit  = pix_hit_q;
    assign bus.pix_idx  = pix_idx_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed scenarios plus a randomized
// pixel stream, all checked against a geometric reference model.
module tb_sprite_blitter;
    import sprite_pkg::*;

    localparam int SIZE     = 16;
    localparam int FRAMES   = 2;
    localparam int ANIM_DIV = 2;
    localparam int IDX_W    = 4;
    localparam int TRANSP   = 0;
    localparam int ADDR_W   = 9;
    localparam int ROM_D    = SIZE * SIZE * FRAMES;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    always #5 vga_clk = ~vga_clk;

    sprite_blitter_if #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

    sprite_blitter #(
        .SIZE(SIZE), .FRAMES(FRAMES), .IDX_W(IDX_W),
        .TRANSP_IDX(TRANSP), .ANIM_DIV(ANIM_DIV)
    ) dut (
        .vga_clk (vga_clk),
        .reset   (reset),
        .bus     (bus)
    );

    logic [IDX_W-1:0] rom_mem [ROM_D];
    always @(posedge vga_clk) bus.rom_q <= rom_mem[bus.rom_addr];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what the sprite should look like right now.
    int m_px, m_py, m_dir, m_steps;
    bit m_en;

    logic [ADDR_W-1:0] obs_addr;
    logic              obs_hit;
    logic [IDX_W-1:0]  obs_idx;

    function automatic int m_frame();
        return (m_steps / ANIM_DIV) % FRAMES;
    endfunction

    function automatic bit m_inbox(int x, int y);
        return x >= m_px && x < m_px + SIZE && y >= m_py && y < m_py + SIZE;
    endfunction

    function automatic int m_addr(int x, int y);
        int lx, ly, sx, sy;
        lx = x - m_px;
        ly = y - m_py;
        case (m_dir)
            0:       begin sx = lx;            sy = ly;            end
            1:       begin sx = ly;            sy = SIZE - 1 - lx; end
            2:       begin sx = SIZE - 1 - lx; sy = SIZE - 1 - ly; end
            default: begin sx = SIZE - 1 - ly; sy = lx;            end
        endcase
        return m_frame() * SIZE * SIZE + sy * SIZE + sx;
    endfunction

    function automatic int m_idx(int x, int y, bit b);
        int v;
        if (!(m_inbox(x, y) && b && m_en)) return 0;
        v = int'(rom_mem[m_addr(x, y)]);
        return (v != TRANSP) ? v : 0;
    endfunction

    function automatic bit m_hit(int x, int y, bit b);
        if (!(m_inbox(x, y) && b && m_en)) return 1'b0;
        return int'(rom_mem[m_addr(x, y)]) != TRANSP;
    endfunction

    function automatic int park_x();
        return (m_px >= SIZE) ? 0 : 1023;
    endfunction

    task automatic model_clear();
        m_px = 0; m_py = 0; m_dir = 0; m_steps = 0; m_en = 1'b0;
    endtask

    task automatic frame_pulse(int px, int py, int d, bit en, bit anim);
        bus.pos_x = 10'(px); bus.pos_y = 10'(py); bus.dir = 2'(d);
        bus.enable = en; bus.anim_en = anim;
        bus.frame_start = 1'b1; bus.blank = 1'b0; bus.DrawX = 10'(park_x());
        @(negedge vga_clk);
        bus.frame_start = 1'b0;
        m_px = px; m_py = py; m_dir = d; m_en = en;
        if (anim) m_steps++;
        // Scramble the request inputs: they must be ignored until the next pulse.
        bus.pos_x = 10'($urandom_range(0, 1023)); bus.pos_y = 10'($urandom_range(0, 1023));
        bus.dir = 2'($urandom_range(0, 3)); bus.enable = 1'($urandom_range(0, 1));
        bus.anim_en = 1'($urandom_range(0, 1));
    endtask

    // Drives one pixel, then parks outside the box; captures n+1 and n+3 outputs.
    task automatic drive_pixel(int x, int y, bit b);
        bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.blank = b;
        @(negedge vga_clk);
        obs_addr = bus.rom_addr;
        bus.DrawX = 10'(park_x()); bus.blank = 1'b0;
        @(negedge vga_clk);
        @(negedge vga_clk);
        obs_hit = bus.pix_hit;
        obs_idx = bus.pix_idx;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge vga_clk);
        n_checks++; if (bus.rom_addr !== '0) begin n_errors++; $display("FAIL reset_addr: got %0d expected 0", bus.rom_addr); end
        n_checks++; if (bus.pix_hit !== 1'b0) begin n_errors++; $display("FAIL reset_hit: got %b expected 0", bus.pix_hit); end
        n_checks++; if (bus.pix_idx !== '0) begin n_errors++; $display("FAIL reset_idx: got %0d expected 0", bus.pix_idx); end
        reset = 1'b0;
        model_clear();
        drive_pixel(0, 0, 1'b1);
        n_checks++; if (obs_addr !== ADDR_W'(m_addr(0, 0))) begin n_errors++; $display("FAIL reset_pix_addr: got %0d expected %0d", obs_addr, m_addr(0, 0)); end
        n_checks++; if (obs_hit !== m_hit(0, 0, 1'b1)) begin n_errors++; $display("FAIL reset_hidden: got %b expected %b", obs_hit, m_hit(0, 0, 1'b1)); end
        $display("test_reset done: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_pixels(string name, int px, int py, int d, int xs[6], int ys[6]);
        frame_pulse(px, py, d, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive_pixel(xs[i], ys[i], 1'b1);
            if (m_inbox(xs[i], ys[i])) begin
                n_checks++; if (obs_addr !== ADDR_W'(m_addr(xs[i], ys[i]))) begin n_errors++; $display("FAIL %s_addr (%0d,%0d): got %0d expected %0d", name, xs[i], ys[i], obs_addr, m_addr(xs[i], ys[i])); end
            end
            n_checks++; if (obs_hit !== m_hit(xs[i], ys[i], 1'b1)) begin n_errors++; $display("FAIL %s_hit (%0d,%0d): got %b expected %b", name, xs[i], ys[i], obs_hit, m_hit(xs[i], ys[i], 1'b1)); end
            n_checks++; if (obs_idx !== IDX_W'(m_idx(xs[i], ys[i], 1'b1))) begin n_errors++; $display("FAIL %s_idx (%0d,%0d): got %0d expected %0d", name, xs[i], ys[i], obs_idx, m_idx(xs[i], ys[i], 1'b1)); end
            $display("%s pixel (%0d,%0d) dir=%0d addr=%0d hit=%b idx=%0d", name, xs[i], ys[i], d, obs_addr, obs_hit, obs_idx);
        end
    endtask

    task automatic test_basic();
        test_pixels("basic", 100, 50, 0, '{100, 115, 116, 107, 99, 100}, '{50, 65, 65, 58, 50, 66});
    endtask

    task automatic test_rotation();
        for (int d = 1; d <= 4; d++)
            test_pixels("rot", 0, 0, d % 4, '{0, 3, 15, 15, 0, 16}, '{0, 7, 15, 0, 15, 0});
    endtask

    task automatic test_edge();
        test_pixels("edge", 630, 470, 0, '{639, 630, 5, 645, 1023, 639}, '{479, 470, 5, 485, 479, 486});
        test_pixels("clip", 1015, 1015, 1, '{1023, 3, 1020, 1015, 1014, 1023}, '{1023, 1020, 2, 1015, 1016, 1014});
    endtask

    task automatic test_anim();
        for (int i = 0; i < 8; i++) begin
            frame_pulse(0, 0, 0, 1'b1, (i < 5));
            drive_pixel(2, 3, 1'b1);
            n_checks++; if (obs_addr !== ADDR_W'(m_addr(2, 3))) begin n_errors++; $display("FAIL anim_addr pulse %0d: got %0d expected %0d", i, obs_addr, m_addr(2, 3)); end
            $display("anim pulse %0d anim_en=%0d addr=%0d", i, (i < 5), obs_addr);
        end
    endtask

    task automatic test_transparency();
        logic [IDX_W-1:0] saved;
        int a;
        frame_pulse(200, 100, 2, 1'b1, 1'b0);
        a = m_addr(205, 110);
        saved = rom_mem[a];
        rom_mem[a] = IDX_W'(TRANSP);
        drive_pixel(205, 110, 1'b1);
        n_checks++; if (obs_hit !== 1'b0 || obs_idx !== '0) begin n_errors++; $display("FAIL transp: got hit=%b idx=%0d expected hit=0 idx=0", obs_hit, obs_idx); end
        rom_mem[a] = saved;
        drive_pixel(205, 110, 1'b0);
        n_checks++; if (obs_hit !== 1'b0) begin n_errors++; $display("FAIL blank_low: got %b expected 0", obs_hit); end
        bus.pos_x = 10'd300;
        drive_pixel(305, 110, 1'b1);
        n_checks++; if (obs_hit !== m_hit(305, 110, 1'b1)) begin n_errors++; $display("FAIL no_move_new: got %b expected %b", obs_hit, m_hit(305, 110, 1'b1)); end
        drive_pixel(210, 110, 1'b1);
        n_checks++; if (obs_hit !== m_hit(210, 110, 1'b1)) begin n_errors++; $display("FAIL no_move_old: got %b expected %b", obs_hit, m_hit(210, 110, 1'b1)); end
        frame_pulse(200, 100, 2, 1'b0, 1'b0);
        drive_pixel(210, 110, 1'b1);
        n_checks++; if (obs_hit !== m_hit(210, 110, 1'b1)) begin n_errors++; $display("FAIL disabled: got %b expected %b", obs_hit, m_hit(210, 110, 1'b1)); end
        $display("test_transparency done: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_reset_mid();
        for (int a = 0; a < ROM_D; a++) rom_mem[a] = IDX_W'($urandom_range(1, 15));
        frame_pulse(0, 0, 0, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            if (k >= 3) begin
                n_checks++; if (bus.pix_hit !== m_hit(k - 3, 0, 1'b1)) begin n_errors++; $display("FAIL pre_reset_hit x=%0d: got %b expected %b", k - 3, bus.pix_hit, m_hit(k - 3, 0, 1'b1)); end
            end
            bus.DrawX = 10'(k); bus.DrawY = 10'd0; bus.blank = 1'b1;
            @(negedge vga_clk);
        end
        reset = 1'b1;
        bus.DrawX = 10'd7;
        @(negedge vga_clk);
        n_checks++; if (bus.rom_addr !== '0 || bus.pix_hit !== 1'b0 || bus.pix_idx !== '0) begin n_errors++; $display("FAIL mid_reset_outputs: got addr=%0d hit=%b idx=%0d expected all 0", bus.rom_addr, bus.pix_hit, bus.pix_idx); end
        reset = 1'b0;
        model_clear();
        for (int k = 0; k < 5; k++) begin
            bus.DrawX = 10'(8 + k);
            @(negedge vga_clk);
            n_checks++; if (bus.pix_hit !== 1'b0) begin n_errors++; $display("FAIL flush_hit cycle %0d: got %b expected 0", k, bus.pix_hit); end
        end
        frame_pulse(0, 0, 0, 1'b1, 1'b0);
        drive_pixel(1, 1, 1'b1);
        n_checks++; if (obs_hit !== m_hit(1, 1, 1'b1)) begin n_errors++; $display("FAIL reenable_hit: got %b expected %b", obs_hit, m_hit(1, 1, 1'b1)); end
        // Reset coinciding with a frame_start that requests visibility.
        reset = 1'b1; bus.frame_start = 1'b1; bus.enable = 1'b1;
        bus.pos_x = 10'd0; bus.pos_y = 10'd0; bus.blank = 1'b0;
        @(negedge vga_clk);
        reset = 1'b0; bus.frame_start = 1'b0;
        model_clear();
        drive_pixel(1, 1, 1'b1);
        n_checks++; if (obs_hit !== m_hit(1, 1, 1'b1)) begin n_errors++; $display("FAIL reset_wins: got %b expected %b", obs_hit, m_hit(1, 1, 1'b1)); end
        $display("test_reset_mid done: checks=%0d errors=%0d", n_checks, n_errors);
    endtask

    task automatic test_random_stream();
        localparam int N = 60;
        int xs[N], ys[N], ea[N], ei[N];
        bit bs[N], inb[N], eh[N];
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < ROM_D; a++)
                rom_mem[a] = ($urandom_range(0, 7) == 0) ? IDX_W'(TRANSP) : IDX_W'($urandom_range(1, 15));
            frame_pulse($urandom_range(0, 1010), $urandom_range(0, 1010), $urandom_range(0, 3),
                        ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            for (int k = 0; k <= N + 2; k++) begin
                if (k >= 1 && inb[k-1]) begin
                    n_checks++; if (bus.rom_addr !== ADDR_W'(ea[k-1])) begin n_errors++; $display("FAIL rand_addr r=%0d k=%0d: got %0d expected %0d", r, k - 1, bus.rom_addr, ea[k-1]); end
                end
                if (k >= 3) begin
                    n_checks++; if (bus.pix_hit !== eh[k-3] || bus.pix_idx !== IDX_W'(ei[k-3])) begin n_errors++; $display("FAIL rand_pix r=%0d k=%0d: got hit=%b idx=%0d expected hit=%b idx=%0d", r, k - 3, bus.pix_hit, bus.pix_idx, eh[k-3], ei[k-3]); end
                end
                if (k < N) begin
                    xs[k] = m_px + $urandom_range(0, SIZE + 3) - 2;
                    ys[k] = m_py + $urandom_range(0, SIZE + 3) - 2;
                    if (xs[k] < 0) xs[k] = 0;
                    if (xs[k] > 1023) xs[k] = 1023;
                    if (ys[k] < 0) ys[k] = 0;
                    if (ys[k] > 1023) ys[k] = 1023;
                    bs[k]  = ($urandom_range(0, 3) != 0);
                    inb[k] = m_inbox(xs[k], ys[k]);
                    ea[k]  = inb[k] ? m_addr(xs[k], ys[k]) : 0;
                    eh[k]  = m_hit(xs[k], ys[k], bs[k]);
                    ei[k]  = m_idx(xs[k], ys[k], bs[k]);
                    bus.DrawX = 10'(xs[k]); bus.DrawY = 10'(ys[k]); bus.blank = bs[k];
                end else begin
                    bus.DrawX = 10'(park_x()); bus.blank = 1'b0;
                end
                @(negedge vga_clk);
            end
            $display("random round %0d pos=(%0d,%0d) dir=%0d en=%b frame=%0d checks=%0d errors=%0d",
                     r, m_px, m_py, m_dir, m_en, m_frame(), n_checks, n_errors);
        end
    endtask

    initial begin
        bus.DrawX = '0; bus.DrawY = '0; bus.blank = 1'b0; bus.frame_start = 1'b0;
        bus.pos_x = '0; bus.pos_y = '0; bus.dir = '0; bus.anim_en = 1'b0; bus.enable = 1'b0;
        for (int a = 0; a < ROM_D; a++) rom_mem[a] = IDX_W'($urandom_range(1, 15));
        model_clear();
        test_reset();
        test_basic();
        test_rotation();
        test_edge();
        test_anim();
        test_transparency();
        test_reset_mid();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
